// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown sequencer.
// FSM state codes and BCD constants.
package countdown_ctrl_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [3:0] BCD_NINE  = 4'd9;

endpackage

// File: rtl/countdown_ctrl_digit.sv
// One BCD digit counting down 9..0 with wrap and borrow.
// Chained by the top to form a two-digit counter.
module bcd_down_digit
  import countdown_ctrl_pkg::*;
#(
  parameter logic [3:0] RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow_out,
  output logic       zero
);

  logic [3:0] r_digit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit <= RST_VAL;
    end else if (load) begin
      r_digit <= load_val;
    end else if (dec) begin
      r_digit <= zero ? BCD_NINE : r_digit - 4'd1;
    end
  end

  assign digit      = r_digit;
  assign zero       = (r_digit == 4'd0);
  assign borrow_out = dec & zero;

endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/load sequencer for secTimer with a
// two-digit BCD countdown and registered status.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter logic [3:0] INIT_TENS = 4'd9,
  parameter logic [3:0] INIT_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       sec_pulse,
  output logic       timer_en,
  output logic       timer_rst,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done,
  output logic       timeout
);

  logic [1:0] r_state;
  logic [1:0] w_nxt;
  logic       r_timer_en;
  logic       r_timer_rst;
  logic       r_running;
  logic       r_done;
  logic       r_timeout;

  logic       w_dec;
  logic       w_ones_borrow;
  logic       w_ones_zero;
  logic       w_tens_borrow;
  logic       w_tens_zero;
  logic       w_cnt_zero;
  logic       w_cnt_one;
  logic [3:0] w_tens;
  logic [3:0] w_ones;

  bcd_down_digit #(.RST_VAL(INIT_ONES)) u_ones (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (INIT_ONES),
    .dec        (w_dec),
    .digit      (w_ones),
    .borrow_out (w_ones_borrow),
    .zero       (w_ones_zero)
  );

  bcd_down_digit #(.RST_VAL(INIT_TENS)) u_tens (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (INIT_TENS),
    .dec        (w_ones_borrow),
    .digit      (w_tens),
    .borrow_out (w_tens_borrow),
    .zero       (w_tens_zero)
  );

  assign w_cnt_zero = w_tens_zero & w_ones_zero;
  assign w_cnt_one  = w_tens_zero & (w_ones == 4'd1);
  // Never decrement at 00, so the digits cannot wrap to 99.
  assign w_dec = (r_state == S_RUN) & sec_pulse
               & ~load & ~w_cnt_zero;

  always_comb begin
    w_nxt = r_state;
    if (load) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !w_cnt_zero) w_nxt = S_RUN;
        end
        S_RUN: begin
          if ((w_dec && w_cnt_one) || w_tens_borrow)
            w_nxt = S_EXPIRED;
          else if (pause)
            w_nxt = S_PAUSE;
        end
        S_PAUSE: begin
          if (start) w_nxt = S_RUN;
        end
        default: w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_timer_en  <= 1'b0;
      r_timer_rst <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_timer_en  <= (w_nxt == S_RUN);
      r_timer_rst <= (w_nxt == S_RUN) | (w_nxt == S_PAUSE);
      r_running   <= (w_nxt == S_RUN);
      r_done      <= (w_nxt == S_EXPIRED);
      r_timeout   <= w_dec & w_cnt_one;
    end
  end

  assign timer_en  = r_timer_en;
  assign timer_rst = r_timer_rst;
  assign tens      = w_tens;
  assign ones      = w_ones;
  assign running   = r_running;
  assign done      = r_done;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scenario and randomized checks of countdown_ctrl
// against an integer-count reference model.
module tb_countdown_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0, start = 1'b0;
  logic pause = 1'b0, sec_pulse = 1'b0;

  logic       a_en, a_trst, a_run, a_done, a_tmo;
  logic [3:0] a_tens, a_ones;
  logic       b_en, b_trst, b_run, b_done, b_tmo;
  logic [3:0] b_tens, b_ones;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  countdown_ctrl u_a (
    .clk(clk), .rst(rst), .load(load), .start(start),
    .pause(pause), .sec_pulse(sec_pulse),
    .timer_en(a_en), .timer_rst(a_trst),
    .tens(a_tens), .ones(a_ones), .running(a_run),
    .done(a_done), .timeout(a_tmo)
  );

  countdown_ctrl #(.INIT_TENS(4'd0), .INIT_ONES(4'd2)) u_b (
    .clk(clk), .rst(rst), .load(load), .start(start),
    .pause(pause), .sec_pulse(sec_pulse),
    .timer_en(b_en), .timer_rst(b_trst),
    .tens(b_tens), .ones(b_ones), .running(b_run),
    .done(b_done), .timeout(b_tmo)
  );

  // Model: seconds remaining as an integer plus a mode.
  // mode 0 idle, 1 run, 2 paused, 3 expired.
  typedef struct {
    int cnt;
    int mode;
    bit tmo;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, int init,
                                bit l, bit s, bit p, bit sp);
    mdl_t n = m;
    n.tmo = 1'b0;
    if (l) begin
      n.cnt = init;
      n.mode = 0;
    end else if (m.mode == 0) begin
      if (s && m.cnt > 0) n.mode = 1;
    end else if (m.mode == 1) begin
      if (sp && m.cnt > 0) begin
        n.cnt = m.cnt - 1;
        if (n.cnt == 0) begin
          n.mode = 3;
          n.tmo = 1'b1;
        end else if (p) n.mode = 2;
      end else if (p) n.mode = 2;
    end else if (m.mode == 2) begin
      if (s) n.mode = 1;
    end
    return n;
  endfunction

  function automatic logic [12:0] exp_vec(mdl_t m);
    logic [3:0] t, o;
    t = 4'(m.cnt / 10);
    o = 4'(m.cnt % 10);
    return {t, o, m.mode == 1, m.mode == 1 || m.mode == 2,
            m.mode == 1, m.mode == 3, m.tmo};
  endfunction

  task automatic model_reset();
    ma = '{cnt: 99, mode: 0, tmo: 1'b0};
    mb = '{cnt: 2, mode: 0, tmo: 1'b0};
  endtask

  task automatic cyc(input bit l, input bit s,
                     input bit p, input bit sp);
    load = l; start = s; pause = p; sec_pulse = sp;
    @(posedge clk);
    ma = step(ma, 99, l, s, p, sp);
    mb = step(mb, 2, l, s, p, sp);
    #1;
    load = 0; start = 0; pause = 0; sec_pulse = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({a_tens, a_ones, a_en, a_trst, a_run, a_done, a_tmo}
        !== {4'd9, 4'd9, 5'b0}) begin
      errs++;
      $display("FAIL reset_a got %h%h %b%b%b%b%b want 99 00000",
               a_tens, a_ones, a_en, a_trst, a_run, a_done, a_tmo);
    end
    checks++;
    if ({b_tens, b_ones, b_en, b_trst, b_run, b_done}
        !== {4'd0, 4'd2, 4'b0}) begin
      errs++;
      $display("FAIL reset_b got %h%h en=%b rst=%b want 02 00",
               b_tens, b_ones, b_en, b_trst);
    end
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_start();
    cyc(0, 1, 0, 0);
    checks++;
    if ({a_run, a_en, a_trst} !== 3'b111) begin
      errs++;
      $display("FAIL start_flags got run/en/rst=%b%b%b want 111",
               a_run, a_en, a_trst);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
    checks++;
    if ({a_tens, a_ones} !== 8'h96) begin
      errs++;
      $display("FAIL start_count got %h%h want 96", a_tens, a_ones);
    end
  endtask

  task automatic test_pause();
    cyc(0, 0, 1, 1);
    checks++;
    if ({a_tens, a_ones, a_run, a_en, a_trst}
        !== {8'h95, 3'b001}) begin
      errs++;
      $display("FAIL pause_enter got %h%h run/en/rst=%b%b%b want 95 001",
               a_tens, a_ones, a_run, a_en, a_trst);
    end
    for (int i = 0; i < 5; i++) cyc(0, 0, i[0], 1);
    checks++;
    if ({a_tens, a_ones, a_trst} !== {8'h95, 1'b1}) begin
      errs++;
      $display("FAIL pause_hold got %h%h trst=%b want 95 1",
               a_tens, a_ones, a_trst);
    end
    cyc(0, 1, 0, 0);
    checks++;
    if ({a_run, a_en, a_trst} !== 3'b111) begin
      errs++;
      $display("FAIL resume got run/en/rst=%b%b%b want 111",
               a_run, a_en, a_trst);
    end
  endtask

  task automatic test_borrow();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1);
    checks++;
    if ({a_tens, a_ones} !== 8'h90) begin
      errs++;
      $display("FAIL borrow_pre got %h%h want 90", a_tens, a_ones);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if ({a_tens, a_ones} !== 8'h89) begin
      errs++;
      $display("FAIL borrow_step got %h%h want 89", a_tens, a_ones);
    end
  endtask

  task automatic test_expiry();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    checks++;
    if ({b_tens, b_ones, b_tmo, b_done} !== {8'h01, 2'b00}) begin
      errs++;
      $display("FAIL expiry_01 got %h%h tmo=%b done=%b want 01 0 0",
               b_tens, b_ones, b_tmo, b_done);
    end
    cyc(0, 0, 1, 1);
    checks++;
    if ({b_tens, b_ones, b_tmo, b_done, b_run, b_trst}
        !== {8'h00, 4'b1100}) begin
      errs++;
      $display("FAIL expiry_00 got %h%h tmo/done/run/trst=%b%b%b%b want 00 1100",
               b_tens, b_ones, b_tmo, b_done, b_run, b_trst);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if ({b_tens, b_ones, b_tmo, b_done} !== {8'h00, 2'b01}) begin
      errs++;
      $display("FAIL expiry_hold got %h%h tmo=%b done=%b want 00 0 1",
               b_tens, b_ones, b_tmo, b_done);
    end
    cyc(0, 1, 0, 0);
    checks++;
    if ({b_run, b_done, b_en} !== 3'b010) begin
      errs++;
      $display("FAIL expiry_start got run/done/en=%b%b%b want 010",
               b_run, b_done, b_en);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if ({b_tens, b_ones, b_done, b_run} !== {8'h02, 2'b00}) begin
      errs++;
      $display("FAIL expiry_load got %h%h done=%b run=%b want 02 0 0",
               b_tens, b_ones, b_done, b_run);
    end
  endtask

  task automatic test_async_run();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 42; i++) cyc(0, 0, 0, 1);
    checks++;
    if ({a_tens, a_ones, a_run} !== {8'h57, 1'b1}) begin
      errs++;
      $display("FAIL async_pre got %h%h run=%b want 57 1",
               a_tens, a_ones, a_run);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({a_tens, a_ones, a_en, a_trst, a_run, a_done, a_tmo}
        !== {8'h99, 5'b0}) begin
      errs++;
      $display("FAIL async_run got %h%h %b%b%b%b%b want 99 00000",
               a_tens, a_ones, a_en, a_trst, a_run, a_done, a_tmo);
    end
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    checks++;
    if ({a_tens, a_ones, a_run} !== {8'h98, 1'b1}) begin
      errs++;
      $display("FAIL async_resume got %h%h run=%b want 98 1",
               a_tens, a_ones, a_run);
    end
  endtask

  task automatic test_random();
    bit l, s, p, sp;
    logic [12:0] ea, eb;
    for (int i = 0; i < 600; i++) begin
      l  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 2) == 0);
      cyc(l, s, p, sp);
      ea = exp_vec(ma);
      eb = exp_vec(mb);
      checks++;
      if ({a_tens, a_ones, a_en, a_trst, a_run, a_done, a_tmo}
          !== ea) begin
        errs++;
        $display("FAIL rand_a cyc=%0d got %h want %h", i,
                 {a_tens, a_ones, a_en, a_trst, a_run, a_done, a_tmo},
                 ea);
      end
      checks++;
      if ({b_tens, b_ones, b_en, b_trst, b_run, b_done, b_tmo}
          !== eb) begin
        errs++;
        $display("FAIL rand_b cyc=%0d got %h want %h", i,
                 {b_tens, b_ones, b_en, b_trst, b_run, b_done, b_tmo},
                 eb);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_pause();
    test_borrow();
    test_expiry();
    test_async_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
